ser_buf_serializer: RTL
=======================

# ser_buf_serializer

Parametrised parallel-to-serial converter with a one-word holding buffer, per-word bit-order selection and valid/ready input handshake. It is the successor to the lab2 serializer. The holding register lets a new word be accepted while the current one is still shifting, so consecutive words go out back-to-back with no idle cycle. It sits between a parallel word producer and a one-bit serial sink.

## Interface
- `DATA_WIDTH`, default 16: parallel word width, ≥ 4.
- `MIN_VALID_LEN`, default 3: shortest length that is transmitted; shorter lengths are discarded.
- `MOD_W`, derived as $clog2(DATA_WIDTH): width of `data_mod_i`.
- `clk_i` input 1: single clock, rising edge.
- `srst_i` input 1: reset, asynchronous assert and active-low.
- `data_i` input DATA_WIDTH: parallel word.
- `data_mod_i` input MOD_W: number of bits to send. 0 means DATA_WIDTH.
- `lsb_first_i` input 1: 0 = MSB-first, 1 = LSB-first. Sampled together with the word.
- `data_val_i` input 1: word valid.
- `data_ready_o` output 1: the block can accept a word.
- `ser_data_o` output 1: serial bit.
- `ser_data_val_o` output 1: `ser_data_o` is valid.
- `busy_o` output 1: a word is shifting or held.

## Operation
**Length decode**
- L = (data_mod_i == 0) ? DATA_WIDTH : data_mod_i.
- If L < MIN_VALID_LEN, the word is invalid.

**Acceptance**
- A word is accepted at a rising edge where `data_val_i && data_ready_o`.
- An invalid word still completes the handshake but is dropped: no output, no state change.

**Bit selection**
- MSB-first sends data[W-1] down to data[W-L].
- LSB-first sends data[0] up to data[L-1].

**Shift-engine states**
- IDLE → SEND when a valid word is accepted, or when the hold register is full.
- SEND → SEND when the last bit is sent and the hold register is full. The held word loads with no gap.
- SEND → IDLE when the last bit is sent and the hold register is empty.

**Routing of accepted words**
- If the engine is IDLE, a valid accepted word loads directly into the shifter.
- Otherwise it loads into the hold register.

**Outputs**
- `data_ready_o` = !hold_full. It comes from a register, with no combinational path from inputs.
- `busy_o` = (state == SEND) || hold_full.
- The bit counter is MOD_W+1 bits wide and counts down from L to 1. Data is not shifted in place; bit index is computed from the counter and the stored order.

## Timing
**Reset values:** `data_ready_o`=0 during reset and 1 after release. `ser_data_o`=0, `ser_data_val_o`=0, `busy_o`=0. State is IDLE and the hold register is empty.

**Latency:** a word accepted at edge N with the engine idle drives its first bit during cycle N+1. It occupies exactly L consecutive cycles with `ser_data_val_o`=1.

**Back-to-back:** the held word's first bit follows the previous word's last bit in the very next cycle.

**Boundary conditions**
- Hold full while the last bit of the current word goes out: the held word moves into the shifter at that edge. `data_ready_o` rises one cycle later; a new word is not accepted in the same cycle.
- `data_val_i` high with ready low: the word is ignored, and the producer must keep it stable.
- Invalid word presented while the hold register is empty and the engine is in SEND: the word is dropped and the hold register stays empty.
- Reset mid-word: all outputs go to their reset values immediately and asynchronously. The shifting word and the held word are lost.
- While idle, `ser_data_o` is 0.

## Structure
- Package `ser_buf_pkg`:
  - `state_t` enum {IDLE, SEND}.
  - Function `decode_len(mod, width)` returning L.
  - Function `len_valid(L, min)`.
- Sub-module `ser_shift_engine` contains the shifter register, counter, order flag, FSM and serial outputs. It has load/done handshake ports.
- The top level holds the hold register, the ready/accept logic and `busy_o`.

## Test plan
All cases use DATA_WIDTH=16.
- Full width: 16'hA5C3, mod 0, MSB-first → 1010 0101 1100 0011 over 16 cycles, with valid high throughout; then `busy_o` falls.
- Short MSB: 16'hB800, mod 5 → bits 1,0,1,1,1 over 5 valid cycles.
- Short LSB: 16'h000D, mod 4, lsb_first=1 → bits 1,0,1,1.
- Invalid: mod 2 → handshake completes; `ser_data_val_o` and `busy_o` stay 0.
- Back-to-back: word A (16'hE000, mod 3) then B (16'h000A, mod 4, LSB-first) on the next cycle → 7 contiguous valid bits 1,1,1,0,1,0,1. `data_ready_o` is low while B is held, and a third word is stalled until ready returns.
- Reset: assert `srst_i` on bit 6 of a 16-bit word → outputs clear the same cycle. After release, a fresh mod-3 word sends correctly.

Source files
------------

// File: rtl/ser_buf_pkg.sv
// Shared types and length helpers for the buffered serializer.
package ser_buf_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Lengths beyond the word width are clamped so the shifter never indexes past the word.
    function automatic int decode_len(input int mod_val, input int width);
        if (mod_val == 0 || mod_val > width) begin
            return width;
        end
        return mod_val;
    endfunction

    function automatic logic len_valid(input int len, input int min_len);
        return len >= min_len;
    endfunction

endpackage

// File: rtl/ser_buf_serializer_if.sv
// Producer-side word handshake plus serial sink outputs of the buffered serializer.
interface ser_buf_serializer_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int MOD_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] data_i;
    logic [MOD_W-1:0]      data_mod_i;
    logic                  lsb_first_i;
    logic                  data_val_i;
    logic                  data_ready_o;
    logic                  ser_data_o;
    logic                  ser_data_val_o;
    logic                  busy_o;

    modport master (
        output data_i, data_mod_i, lsb_first_i, data_val_i,
        input  data_ready_o, ser_data_o, ser_data_val_o, busy_o
    );

    modport slave (
        input  data_i, data_mod_i, lsb_first_i, data_val_i,
        output data_ready_o, ser_data_o, ser_data_val_o, busy_o
    );

endinterface

// File: rtl/ser_shift_engine.sv
// Shift engine: stores one word and emits L bits, picking each bit by index
// from the down-counter and the stored order rather than shifting in place.
module ser_shift_engine
    import ser_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MOD_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [MOD_W:0]        load_len,
    input  logic                  load_lsb,
    output logic                  done,
    output logic                  idle,
    output logic                  ser_data,
    output logic                  ser_data_val
);

    localparam int LEN_W = MOD_W + 1;
    localparam logic [MOD_W-1:0] TOP_IDX = MOD_W'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt;
    logic                  lsb_q;

    function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic                  lsb,
                                      input logic [LEN_W-1:0]      len,
                                      input logic [LEN_W-1:0]      c);
        logic [LEN_W-1:0] sent;
        logic [MOD_W-1:0] idx;
        sent = len - c;
        idx  = lsb ? sent[MOD_W-1:0] : TOP_IDX - sent[MOD_W-1:0];
        return d[idx];
    endfunction

    assign done = (state == SEND) && (cnt == LEN_W'(1));
    assign idle = (state == IDLE);

    // A load always wins; it is only issued when idle or on the last bit, giving gapless words.
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            state        <= IDLE;
            shreg        <= '0;
            len_q        <= '0;
            cnt          <= '0;
            lsb_q        <= 1'b0;
            ser_data     <= 1'b0;
            ser_data_val <= 1'b0;
        end else if (load) begin
            state        <= SEND;
            shreg        <= load_data;
            len_q        <= load_len;
            cnt          <= load_len;
            lsb_q        <= load_lsb;
            ser_data     <= pick_bit(load_data, load_lsb, load_len, load_len);
            ser_data_val <= 1'b1;
        end else if (state == SEND) begin
            if (cnt == LEN_W'(1)) begin
                state        <= IDLE;
                cnt          <= '0;
                ser_data     <= 1'b0;
                ser_data_val <= 1'b0;
            end else begin
                cnt      <= cnt - LEN_W'(1);
                ser_data <= pick_bit(shreg, lsb_q, len_q, cnt - LEN_W'(1));
            end
        end
    end

endmodule

// File: rtl/ser_buf_serializer.sv
// Buffered parallel-to-serial converter: accept/ready logic and a one-word
// hold register in front of the shift engine.
module ser_buf_serializer
    import ser_buf_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int MIN_VALID_LEN = 3,
    parameter int MOD_W         = $clog2(DATA_WIDTH)
) (
    input  logic                clk_i,
    input  logic                srst_i,
    ser_buf_serializer_if.slave bus
);

    localparam int LEN_W = MOD_W + 1;

    logic [DATA_WIDTH-1:0] hold_data;
    logic [LEN_W-1:0]      hold_len;
    logic                  hold_lsb;
    logic                  hold_full;
    logic                  hold_full_next;
    logic                  ready_q;

    logic [LEN_W-1:0]      in_len;
    logic                  word_ok;
    logic                  take_new;
    logic                  eng_done;
    logic                  eng_idle;
    logic                  eng_free;
    logic                  from_hold;
    logic                  to_hold;
    logic                  eng_load;
    logic [DATA_WIDTH-1:0] eng_data;
    logic [LEN_W-1:0]      eng_len;
    logic                  eng_lsb;

    assign in_len   = LEN_W'(decode_len(int'(bus.data_mod_i), DATA_WIDTH));
    assign word_ok  = len_valid(int'(in_len), MIN_VALID_LEN);
    assign take_new = bus.data_val_i && ready_q && word_ok;

    // The engine can take a word now if idle or finishing its last bit this cycle.
    assign eng_free  = eng_idle || eng_done;
    assign from_hold = hold_full && eng_free;
    assign to_hold   = take_new && !eng_free;
    assign eng_load  = from_hold || (take_new && eng_free);

    assign eng_data = from_hold ? hold_data : bus.data_i;
    assign eng_len  = from_hold ? hold_len  : in_len;
    assign eng_lsb  = from_hold ? hold_lsb  : bus.lsb_first_i;

    assign hold_full_next = to_hold ? 1'b1 : (from_hold ? 1'b0 : hold_full);

    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            hold_data <= '0;
            hold_len  <= '0;
            hold_lsb  <= 1'b0;
            hold_full <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            if (to_hold) begin
                hold_data <= bus.data_i;
                hold_len  <= in_len;
                hold_lsb  <= bus.lsb_first_i;
            end
            hold_full <= hold_full_next;
            ready_q   <= !hold_full_next;
        end
    end

    ser_shift_engine #(
        .DATA_WIDTH (DATA_WIDTH),
        .MOD_W      (MOD_W)
    ) u_engine (
        .clk_i        (clk_i),
        .srst_i       (srst_i),
        .load         (eng_load),
        .load_data    (eng_data),
        .load_len     (eng_len),
        .load_lsb     (eng_lsb),
        .done         (eng_done),
        .idle         (eng_idle),
        .ser_data     (bus.ser_data_o),
        .ser_data_val (bus.ser_data_val_o)
    );

    assign bus.data_ready_o = ready_q;
    assign bus.busy_o       = !eng_idle || hold_full;

endmodule
